uart_clk_arbiter: RTL

UART_CLK_ARBITER -- requirements
Module: uart_clk_arbiter

---
 rtl/uart_clk_pkg.sv | 30 +++
 rtl/uart_clk_arbiter_rr_pick.sv | 37 +++
 rtl/uart_clk_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_clk_pkg.sv
// Shared types for the UART clock-generator arbiter.
// Holds the state encoding, the divider width and small index helpers.
package uart_clk_pkg;

  localparam int DIV_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_GRANTED = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

  // Generator runs only while settling or owned.
  function automatic logic gen_on(
    input state_e s
  );
    return (s == ST_SETTLE) || (s == ST_GRANTED);
  endfunction

endpackage

// File: rtl/uart_clk_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after
// the pointer, wrapping past N-1 back to 0.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW:0]   pos;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      cand = pos[IW-1:0];
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_clk_arbiter.sv
// Arbitrates one shared UART clock generator between NUM_REQ users.
// Config is latched at arbitration; enable settles before grant.
module uart_clk_arbiter
  import uart_clk_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SETTLE  = 4
) (
  input  logic                     clk,
  input  logic                     en_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       cfg_freq,
  input  logic [DIV_W*NUM_REQ-1:0] cfg_div,
  output logic                     gen_en,
  output logic                     gen_freq,
  output logic [DIV_W-1:0]         gen_div,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_e state_q, state_d;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               freq_q, freq_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               gen_en_q, gen_en_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [DIV_W-1:0]   pick_div;
  logic               win_req;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    pick_div = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_div = cfg_div[DIV_W*i +: DIV_W];
      end
    end
  end

  assign win_req = req[win_q];

  always_ff @(posedge clk or negedge en_rst) begin
    if (!en_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = win_req ? ST_SETTLE : ST_DRAIN;
      end
      ST_SETTLE: begin
        if (!win_req) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!win_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    win_d  = win_q;
    freq_d = freq_q;
    div_d  = div_q;
    cnt_d  = '0;
    if (state_q == ST_IDLE && pick_any) begin
      win_d  = pick_idx;
      freq_d = |(cfg_freq & pick_oh);
      div_d  = pick_div;
    end
    if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == ST_DRAIN) begin
      ptr_d = IW'(wrap_inc(int'(win_q), NUM_REQ));
    end
  end

  // Enable and grant need both the current and next state to agree,
  // which gives the two-edge enable latency and drops both on exit.
  always_comb begin
    gen_en_d = gen_on(state_q) && gen_on(state_d);
    gnt_d    = '0;
    if (state_q == ST_GRANTED && state_d == ST_GRANTED) begin
      gnt_d[win_q] = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge en_rst) begin
    if (!en_rst) begin
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      freq_q   <= 1'b0;
      div_q    <= '0;
      gen_en_q <= 1'b0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      freq_q   <= freq_d;
      div_q    <= div_d;
      gen_en_q <= gen_en_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
    end
  end

  assign gen_en   = gen_en_q;
  assign gen_freq = freq_q;
  assign gen_div  = div_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;

endmodule
